// File: rtl/agu_pkg.sv
// Shared defaults, width helpers and state encoding for the AGU sequencer.
package agu_pkg;

  localparam int DEGREE_DEF = 16;
  localparam int K_DEF      = 4;

  // Width of the point index: counts 0 .. degree-1.
  function automatic int pt_width(input int degree);
    return $clog2(degree);
  endfunction

  // Width of the iteration index: counts 0 .. k (saturates at k).
  function automatic int it_width(input int k);
    return $clog2(k + 1);
  endfunction

  // Width of the accepted-address counter: counts 0 .. degree*k.
  function automatic int oc_width(input int degree, input int k);
    return $clog2(degree * k + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } agu_state_t;

endpackage

// File: rtl/agu_seq_ctrl_if.sv
// Control/status bundle between the AGU sequencer and its environment.
interface agu_seq_ctrl_if
  import agu_pkg::*;
#(
  parameter int DEGREE = DEGREE_DEF,
  parameter int K      = K_DEF
);

  logic                                start;
  logic                                abort;
  logic                                out_ready;
  logic                                bn_ma_out_en;
  logic                                agu_done_in;
  logic                                agu_enable;
  logic [pt_width(DEGREE)-1:0]         pt_idx;
  logic [it_width(K)-1:0]              it_idx;
  logic [oc_width(DEGREE, K)-1:0]      out_cnt;
  logic                                busy;
  logic                                done;
  logic                                err;

  modport slave (
    input  start, abort, out_ready, bn_ma_out_en, agu_done_in,
    output agu_enable, pt_idx, it_idx, out_cnt, busy, done, err
  );

  modport master (
    output start, abort, out_ready, bn_ma_out_en, agu_done_in,
    input  agu_enable, pt_idx, it_idx, out_cnt, busy, done, err
  );

endinterface

// File: rtl/agu_wrap_cnt.sv
// Up-counter with clear and enable; at MAX it either wraps to 0 or holds.
module agu_wrap_cnt #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1,
  parameter bit               SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  // count register: clear has priority over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == MAX) cnt <= SAT ? MAX : '0;
      else            cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/agu_seq_ctrl.sv
// Sequencer that steps the AGU through K iterations of DEGREE points and
// counts the addresses it hands back.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; counters hold their last values
//   ST_RUN   | enabling the AGU whenever downstream is ready
//   ST_DRAIN | all addresses issued, collecting the remaining strobes
//   ST_DONE  | one-cycle completion pulse, then back to idle
module agu_seq_ctrl
  import agu_pkg::*;
#(
  parameter int DEGREE = DEGREE_DEF,
  parameter int K      = K_DEF
) (
  input logic           clk,
  input logic           rst,
  agu_seq_ctrl_if.slave bus
);

  localparam int PT_W = pt_width(DEGREE);
  localparam int IT_W = it_width(K);
  localparam int OC_W = oc_width(DEGREE, K);
  localparam logic [OC_W-1:0] TOTAL = OC_W'(DEGREE * K);

  agu_state_t      state_q, state_d;
  logic            en;
  logic            cnt_clr;
  logic            oc_inc;
  logic            pt_wrap;
  logic            it_last;
  logic [PT_W-1:0] pt_idx;
  logic [IT_W-1:0] it_idx;
  logic [OC_W-1:0] out_cnt_q;
  logic [OC_W-1:0] oc_next;
  logic            err_q;

  assign pt_wrap = (pt_idx == PT_W'(DEGREE - 1));
  assign it_last = (it_idx == IT_W'(K - 1));
  // Strobes count only while a transform is live and not being aborted.
  assign oc_inc  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                   bus.bn_ma_out_en && !bus.abort;
  assign oc_next = out_cnt_q + OC_W'(oc_inc);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic and AGU enable; abort overrides everything
  always_comb begin
    state_d = state_q;
    en      = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          en = bus.out_ready;
          if (en && pt_wrap && it_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.abort)                                  state_d = ST_IDLE;
        else if ((oc_next >= TOTAL) || bus.agu_done_in) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // accepted-address counter, cleared by an honoured start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         out_cnt_q <= '0;
    else if (cnt_clr) out_cnt_q <= '0;
    else              out_cnt_q <= oc_next;
  end

  // sticky error: stray strobe while idle, or short count at completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     err_q <= 1'b0;
    else if (cnt_clr)                             err_q <= 1'b0;
    else if ((state_q == ST_IDLE) && bus.bn_ma_out_en)
                                                  err_q <= 1'b1;
    else if ((state_q == ST_DRAIN) && (state_d == ST_DONE) && (oc_next != TOTAL))
                                                  err_q <= 1'b1;
  end

  agu_wrap_cnt #(
    .WIDTH (PT_W),
    .MAX   (PT_W'(DEGREE - 1)),
    .SAT   (1'b0)
  ) u_pt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (en),
    .cnt (pt_idx)
  );

  agu_wrap_cnt #(
    .WIDTH (IT_W),
    .MAX   (IT_W'(K)),
    .SAT   (1'b1)
  ) u_it_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (en && pt_wrap),
    .cnt (it_idx)
  );

  assign bus.agu_enable = en;
  assign bus.pt_idx     = pt_idx;
  assign bus.it_idx     = it_idx;
  assign bus.out_cnt    = out_cnt_q;
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_agu_seq_ctrl.sv
// Directed bench for agu_seq_ctrl (DEGREE=16, K=4) with a completion scoreboard.
module tb_agu_seq_ctrl;
  import agu_pkg::*;

  localparam int DEG = DEGREE_DEF;
  localparam int KK  = K_DEF;

  typedef struct {
    int en_cnt;
    int out_cnt;
    int err;
    int drain;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   drop_tail = 1'b0;
  exp_t exp_q[$];

  agu_seq_ctrl_if #(.DEGREE(DEG), .K(KK)) bus ();

  agu_seq_ctrl #(.DEGREE(DEG), .K(KK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_agu_enable"}, 32'(bus.agu_enable), 0);
    chk({pfx, "_busy"},       32'(bus.busy),       0);
    chk({pfx, "_done"},       32'(bus.done),       0);
    chk({pfx, "_err"},        32'(bus.err),        0);
    chk({pfx, "_pt_idx"},     32'(bus.pt_idx),     0);
    chk({pfx, "_it_idx"},     32'(bus.it_idx),     0);
    chk({pfx, "_out_cnt"},    32'(bus.out_cnt),    0);
  endtask

  task automatic push_exp(input int en_cnt, input int oc, input int e, input int drain);
    exp_t x;
    x.en_cnt = en_cnt; x.out_cnt = oc; x.err = e; x.drain = drain;
    exp_q.push_back(x);
  endtask

  task automatic do_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_pt_it(input int pt, input int it, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(int'(bus.pt_idx) == pt && int'(bus.it_idx) == it) && n < 300);
    if (!(int'(bus.pt_idx) == pt && int'(bus.it_idx) == it))
      chk({nm, "_reach_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.done && n < 300);
    if (!bus.done) begin
      chk({nm, "_done_timeout"}, 0, 1);
    end else begin
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, 32'(bus.done), 0);
      chk({nm, "_idle_after_done"}, 32'(bus.busy), 0);
    end
  endtask

  // Returns one strobe per enabled cycle, three cycles later.
  initial begin : strobe_gen
    logic [2:0] hist;
    hist = '0;
    bus.bn_ma_out_en = 1'b0;
    forever begin
      @(negedge clk);
      hist = {hist[1:0], bus.agu_enable};
      @(posedge clk); #1;
      bus.bn_ma_out_en = hist[2] && !(drop_tail && bus.out_cnt >= 7'd63);
    end
  end

  // Scoreboard monitor: counts enables, compares on every done pulse.
  initial begin : monitor
    int   en_seen;
    int   since_en;
    exp_t e;
    en_seen = 0; since_en = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        en_seen = 0; since_en = 0;
      end else begin
        if (bus.start && !bus.abort && !bus.busy && !bus.done) begin
          en_seen = 0; since_en = 0;
        end
        if (bus.agu_enable) begin
          en_seen++; since_en = 0;
        end else if (bus.busy) begin
          since_en++;
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_enable_count", 32'(en_seen), 32'(e.en_cnt));
            chk("sb_out_cnt", 32'(bus.out_cnt), 32'(e.out_cnt));
            chk("sb_err", 32'(bus.err), 32'(e.err));
            if (e.drain >= 0) chk("sb_drain_cycles", 32'(since_en), 32'(e.drain));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1; bus.agu_done_in = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain transform, strobes lag by 3
    push_exp(64, 64, 0, 3);
    do_start();
    #1;
    chk("s1_latency_enable", 32'(bus.agu_enable), 1);
    chk("s1_first_pt", 32'(bus.pt_idx), 0);
    chk("s1_busy", 32'(bus.busy), 1);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!(bus.busy && !bus.agu_enable) && n < 200);
      chk("s1_in_drain", 32'(bus.busy && !bus.agu_enable), 1);
      chk("s1_it_saturated", 32'(bus.it_idx), 4);
      chk("s1_pt_wrapped", 32'(bus.pt_idx), 0);
      chk("s1_drain_entry_cnt", 32'(bus.out_cnt), 61);
    end
    wait_done("s1");

    // 2: out_ready stall at pt=7, it=2
    push_exp(64, 64, 0, 3);
    do_start();
    wait_pt_it(6, 2, "s2");
    @(posedge clk); #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s2_stall_enable", 32'(bus.agu_enable), 0);
      chk("s2_stall_pt", 32'(bus.pt_idx), 7);
      chk("s2_stall_it", 32'(bus.it_idx), 2);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done("s2");

    // 3: abort at it=1, then restart
    do_start();
    wait_pt_it(2, 1, "s3");
    @(posedge clk); #1 bus.abort = 1'b1;
    #1 chk("s3_abort_enable_low", 32'(bus.agu_enable), 0);
    @(posedge clk); #1 bus.abort = 1'b0;
    chk("s3_idle_after_abort", 32'(bus.busy), 0);
    chk("s3_pt_hold", 32'(bus.pt_idx), 3);
    chk("s3_it_hold", 32'(bus.it_idx), 1);
    repeat (5) @(negedge clk);
    chk("s3_err_idle_strobe", 32'(bus.err), 1);
    chk("s3_pt_still_held", 32'(bus.pt_idx), 3);
    push_exp(64, 64, 0, 3);
    do_start();
    #1;
    chk("s3_restart_pt", 32'(bus.pt_idx), 0);
    chk("s3_restart_it", 32'(bus.it_idx), 0);
    chk("s3_restart_err_clr", 32'(bus.err), 0);
    wait_done("s3");

    // 4: last strobe missing, AGU reports done
    drop_tail = 1'b1;
    push_exp(64, 63, 1, -1);
    do_start();
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (int'(bus.out_cnt) != 63 && n < 200);
      chk("s4_reach_63", 32'(bus.out_cnt), 63);
    end
    repeat (3) @(negedge clk);
    chk("s4_waiting_in_drain", 32'(bus.busy), 1);
    @(posedge clk); #1 bus.agu_done_in = 1'b1;
    @(posedge clk); #1 bus.agu_done_in = 1'b0;
    wait_done("s4");
    drop_tail = 1'b0;

    // 5: reset pulse mid-run, then a full transform
    do_start();
    wait_pt_it(4, 2, "s5");
    @(posedge clk); #1 rst = 1'b0;
    #1 chk_all_zero("s5_async_reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    push_exp(64, 64, 0, 3);
    do_start();
    wait_done("s5");

    // 6: start during RUN is ignored
    push_exp(64, 64, 0, 3);
    do_start();
    wait_pt_it(4, 1, "s6");
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("s6_pt_not_restarted", 32'(bus.pt_idx), 6);
    chk("s6_it_not_restarted", 32'(bus.it_idx), 1);
    chk("s6_err_clear", 32'(bus.err), 0);
    wait_done("s6");

    repeat (3) @(negedge clk);
    chk("sb_all_consumed", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
